// File: rtl/neural_pkg.sv
`default_nettype none
// ============================================================================
// Module   : neural_pkg
// Brief    : Shared types and constants for the neural SIMD sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package neural_pkg;

    localparam int c_lane_w = 8;
    localparam int c_lanes  = 4;
    localparam int c_data_w = c_lane_w * c_lanes;

    localparam logic [1:0] MODE_MASK   = 2'd0;
    localparam logic [1:0] MODE_BRIGHT = 2'd1;
    localparam logic [1:0] MODE_BLEND  = 2'd2;
    localparam logic [1:0] MODE_DIFF   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD_A = 3'd1,
        ST_WT_A = 3'd2,
        ST_RD_B = 3'd3,
        ST_WT_B = 3'd4,
        ST_EXEC = 3'd5,
        ST_WR   = 3'd6,
        ST_DONE = 3'd7
    } state_t;

endpackage
`default_nettype wire

// File: rtl/neural_simd_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : neural_simd_seq_if
// Brief    : Command, memory-port and SIMD-operand bus of the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface neural_simd_seq_if
    import neural_pkg::*;
#(
    parameter int AW = 16,
    parameter int LW = 16
);

    logic                cmd_valid;
    logic                cmd_ready;
    logic [1:0]          cmd_mode;
    logic [c_data_w-1:0] cmd_param;
    logic                cmd_use_b;
    logic [AW-1:0]       cmd_src_a;
    logic [AW-1:0]       cmd_src_b;
    logic [AW-1:0]       cmd_dst;
    logic [LW-1:0]       cmd_len;

    logic                mem_req;
    logic                mem_we;
    logic [AW-1:0]       mem_addr;
    logic [c_data_w-1:0] mem_wdata;
    logic                mem_gnt;
    logic                mem_rvalid;
    logic [c_data_w-1:0] mem_rdata;

    logic [1:0]          simd_mode;
    logic [c_data_w-1:0] simd_rs1;
    logic [c_data_w-1:0] simd_rs2;
    logic [c_data_w-1:0] simd_param;
    logic [c_data_w-1:0] simd_rd;

    logic                busy;
    logic                done;
    logic [LW-1:0]       words_done;

    modport master (
        input  cmd_valid, cmd_mode, cmd_param, cmd_use_b, cmd_src_a, cmd_src_b,
               cmd_dst, cmd_len, mem_gnt, mem_rvalid, mem_rdata, simd_rd,
        output cmd_ready, mem_req, mem_we, mem_addr, mem_wdata, simd_mode,
               simd_rs1, simd_rs2, simd_param, busy, done, words_done
    );

    modport slave (
        output cmd_valid, cmd_mode, cmd_param, cmd_use_b, cmd_src_a, cmd_src_b,
               cmd_dst, cmd_len, mem_gnt, mem_rvalid, mem_rdata, simd_rd,
        input  cmd_ready, mem_req, mem_we, mem_addr, mem_wdata, simd_mode,
               simd_rs1, simd_rs2, simd_param, busy, done, words_done
    );

endinterface
`default_nettype wire

// File: rtl/neural_simd_seq.sv
`default_nettype none
// ============================================================================
// Module   : neural_simd_seq
// Brief    : Streams packed pixel words from memory through the SIMD datapath
//            and writes results back, one memory transaction at a time.
// Revision : 1.0 - initial release
// ============================================================================
module neural_simd_seq
    import neural_pkg::*;
#(
    parameter int AW       = 16,
    parameter int LW       = 16,
    parameter int SIMD_LAT = 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    neural_simd_seq_if.master  bus
);

    localparam int                 c_lat_w    = (SIMD_LAT > 1) ? $clog2(SIMD_LAT) : 1;
    localparam logic [c_lat_w-1:0] c_lat_last = c_lat_w'(SIMD_LAT - 1);

    state_t              r_state;
    state_t              w_next;

    logic [1:0]          r_mode;
    logic [c_data_w-1:0] r_param;
    logic                r_use_b;
    logic [AW-1:0]       r_a_ptr;
    logic [AW-1:0]       r_b_ptr;
    logic [AW-1:0]       r_d_ptr;
    logic [LW-1:0]       r_len;
    logic [LW-1:0]       r_words_done;
    logic [c_data_w-1:0] r_rs1;
    logic [c_data_w-1:0] r_rs2;
    logic [c_data_w-1:0] r_wdata;
    logic [c_lat_w-1:0]  r_lat_cnt;

    logic                w_lat_last;
    logic [LW-1:0]       w_words_inc;
    logic                w_last_word;

    logic                w_cmd_ready;
    logic                w_busy;
    logic                w_done;
    logic                w_mem_req;
    logic                w_mem_we;
    logic [AW-1:0]       w_mem_addr;

    assign w_lat_last  = (r_lat_cnt == c_lat_last);
    assign w_words_inc = r_words_done + LW'(1);
    assign w_last_word = (w_words_inc == r_len);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (bus.cmd_valid) w_next = (bus.cmd_len == '0) ? ST_DONE : ST_RD_A;
            ST_RD_A: if (bus.mem_gnt)    w_next = ST_WT_A;
            ST_WT_A: if (bus.mem_rvalid) w_next = r_use_b ? ST_RD_B : ST_EXEC;
            ST_RD_B: if (bus.mem_gnt)    w_next = ST_WT_B;
            ST_WT_B: if (bus.mem_rvalid) w_next = ST_EXEC;
            ST_EXEC: if (w_lat_last)     w_next = ST_WR;
            ST_WR:   if (bus.mem_gnt)    w_next = w_last_word ? ST_DONE : ST_RD_A;
            ST_DONE:                     w_next = ST_IDLE;
            default:                     w_next = ST_IDLE;
        endcase
    end

    // Address and direction depend on state only, so they hold while a request waits for grant.
    always_comb begin
        w_cmd_ready = 1'b0;
        w_busy      = 1'b1;
        w_done      = 1'b0;
        w_mem_req   = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = '0;
        case (r_state)
            ST_IDLE: begin
                w_cmd_ready = 1'b1;
                w_busy      = 1'b0;
            end
            ST_RD_A: begin
                w_mem_req  = 1'b1;
                w_mem_addr = r_a_ptr;
            end
            ST_RD_B: begin
                w_mem_req  = 1'b1;
                w_mem_addr = r_b_ptr;
            end
            ST_WR: begin
                w_mem_req  = 1'b1;
                w_mem_we   = 1'b1;
                w_mem_addr = r_d_ptr;
            end
            ST_DONE: w_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode       <= '0;
            r_param      <= '0;
            r_use_b      <= 1'b0;
            r_a_ptr      <= '0;
            r_b_ptr      <= '0;
            r_d_ptr      <= '0;
            r_len        <= '0;
            r_words_done <= '0;
            r_rs1        <= '0;
            r_rs2        <= '0;
            r_wdata      <= '0;
            r_lat_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_mode       <= bus.cmd_mode;
                        r_param      <= bus.cmd_param;
                        r_use_b      <= bus.cmd_use_b;
                        r_a_ptr      <= bus.cmd_src_a;
                        r_b_ptr      <= bus.cmd_src_b;
                        r_d_ptr      <= bus.cmd_dst;
                        r_len        <= bus.cmd_len;
                        r_words_done <= '0;
                        r_rs2        <= '0;
                        r_lat_cnt    <= '0;
                    end
                end
                ST_WT_A: if (bus.mem_rvalid) r_rs1 <= bus.mem_rdata;
                ST_WT_B: if (bus.mem_rvalid) r_rs2 <= bus.mem_rdata;
                ST_EXEC: begin
                    if (w_lat_last) begin
                        r_wdata   <= bus.simd_rd;
                        r_lat_cnt <= '0;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + c_lat_w'(1);
                    end
                end
                ST_WR: begin
                    if (bus.mem_gnt) begin
                        r_a_ptr      <= r_a_ptr + AW'(1);
                        r_b_ptr      <= r_b_ptr + AW'(1);
                        r_d_ptr      <= r_d_ptr + AW'(1);
                        r_words_done <= w_words_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.cmd_ready  = w_cmd_ready;
    assign bus.busy       = w_busy;
    assign bus.done       = w_done;
    assign bus.words_done = r_words_done;
    assign bus.mem_req    = w_mem_req;
    assign bus.mem_we     = w_mem_we;
    assign bus.mem_addr   = w_mem_addr;
    assign bus.mem_wdata  = r_wdata;
    assign bus.simd_mode  = r_mode;
    assign bus.simd_param = r_param;
    assign bus.simd_rs1   = r_rs1;
    assign bus.simd_rs2   = r_rs2;

endmodule
`default_nettype wire

// File: doc/neural_simd_seq.md
Name: neural_simd_seq

Overview:
Sequencer that streams a buffer of packed 4x8-bit pixel words through the 4-lane neural SIMD datapath without CPU involvement. It accepts one command (mode, param, source/destination word addresses, length), fetches operand words over a single-outstanding memory port, holds them on the SIMD operand bus for the datapath latency, captures the result and writes it back. It sits between the command/CSR front end and the SIMD datapath plus its local pixel memory.

Parameters:
AW, 16, word-address width of the memory port
LW, 16, width of the length and progress counters
SIMD_LAT, 1, clock cycles from stable SIMD operands to valid rd (>=1)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  high only in IDLE
cmd_mode  in  2  SIMD mode for the whole job
cmd_param  in  32  per-lane param (mask/brightness)
cmd_use_b  in  1  1 = fetch second operand stream (blend-type modes)
cmd_src_a  in  AW  first word address of stream A
cmd_src_b  in  AW  first word address of stream B
cmd_dst  in  AW  first word address of results
cmd_len  in  LW  number of words
mem_req  out  1  request, held until mem_gnt
mem_we  out  1  1 = write, 0 = read
mem_addr  out  AW  word address
mem_wdata  out  32  write data
mem_gnt  in  1  request accepted this cycle
mem_rvalid  in  1  read data valid, >=1 cycle after read grant
mem_rdata  in  32  read data
simd_mode  out  2  to datapath mode
simd_rs1  out  32  operand A
simd_rs2  out  32  operand B (0 when use_b=0)
simd_param  out  32  to datapath param
simd_rd  in  32  datapath result
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at job end
words_done  out  LW  words written in current/last job

Behaviour:
- Reset: state IDLE; all outputs 0 except cmd_ready=1; job registers and counters cleared. Reset mid-job aborts immediately; an mem_rvalid arriving after reset release is ignored (IDLE ignores rvalid).
- IDLE: cmd_ready=1. On cmd_valid: latch all cmd fields, clear words_done, clear rs2 register, go RD_A; if cmd_len==0 go DONE (no memory traffic).
- RD_A: mem_req=1, we=0, addr=a_ptr; on mem_gnt -> WT_A. WT_A: on mem_rvalid latch rdata to rs1 reg; next RD_B if use_b else EXEC.
- RD_B/WT_B: same with b_ptr, latch into rs2 reg; next EXEC.
- EXEC: operands stable on simd_rs1/rs2; latency counter runs SIMD_LAT cycles; on last count latch simd_rd into wdata reg -> WR.
- WR: mem_req=1, we=1, addr=d_ptr, wdata; on mem_gnt: a_ptr/b_ptr/d_ptr +1 (wrap mod 2^AW), words_done+1; if words_done+1==len -> DONE else RD_A.
- DONE: done=1 for exactly one cycle -> IDLE. words_done holds final value until next accept.
- simd_mode/simd_param driven from latched registers, stable for whole job; simd_rs1/rs2 change only on rvalid latch.
- mem_req never dropped before mem_gnt; address/we/wdata stable while req high. Only one transaction outstanding. cmd_valid outside IDLE ignored.
- Per-word cost: use_b=0 with zero-wait memory and 1-cycle rvalid: RD_A,WT_A,EXEC*SIMD_LAT,WR = 3+SIMD_LAT cycles.

Decomposition:
- Package neural_pkg: state enum (IDLE,RD_A,WT_A,RD_B,WT_B,EXEC,WR,DONE), SIMD mode constants, lane width 8 and lane count 4.
- Single module; no sub-module (latency counter inline). neural_simd instantiated by the parent, not inside this block.

Test Plan:
- Bench model: SIMD stub rd=rs1^param registered SIMD_LAT cycles; memory zero-wait grant, rvalid 1 cycle later.
- Single word: len=1, use_b=0, param=0x000000FF, mem[src_a=0x10]=0x11223344 -> one write mem[dst=0x20]=0x112233BB, done pulse, words_done=1, total 5 cycles accept-to-done.
- Blend stream: len=3, use_b=1 -> read order A0,B0,A1,B1,A2,B2 interleaved with writes; simd_rs2 equals B word at each EXEC; 3 writes to dst..dst+2.
- Zero length: cmd_len=0 -> no mem_req, done pulse 2nd cycle after accept, words_done=0.
- Back-pressure/wrap: mem_gnt delayed 4 cycles randomly, src_a=0xFFFF, len=2 -> req/addr stable while waiting; second read at 0x0000.
- Reset mid-job: assert rst during WT_A, then rvalid after release -> busy=0, mem_req=0, no write issued, cmd_ready=1.
